// File: rtl/register_request_encoder_pkg.sv
// Shared register-file definitions: index width, bit-order convention, encoder states.
// Register i lives at vector bit (15-i), matching the write-enable decoder's one-hot order.
package register_request_encoder_pkg;

    localparam int REG_COUNT   = 16;
    localparam int REG_INDEX_W = 4;

    typedef logic [REG_COUNT-1:0]   reg_vec_t;
    typedef logic [REG_INDEX_W-1:0] reg_idx_t;

    typedef enum logic {
        ENC_IDLE  = 1'b0,
        ENC_DRAIN = 1'b1
    } enc_state_t;

    function automatic reg_idx_t reg_bit(input reg_idx_t i);
        return reg_idx_t'(4'd15 - i);
    endfunction

    function automatic reg_vec_t reg_onehot(input reg_idx_t i);
        return reg_vec_t'(1) << reg_bit(i);
    endfunction

    function automatic logic [4:0] popcount(input reg_vec_t v);
        logic [4:0] n;
        n = '0;
        for (int k = 0; k < REG_COUNT; k++) begin
            n = n + {4'd0, v[k]};
        end
        return n;
    endfunction

endpackage

// File: rtl/register_request_encoder_priority_index_select.sv
// Finds the first set register at or after start, wrapping ascending through 16 indices.
// Purely combinational; no state, no backpressure.
module priority_index_select
    import register_request_encoder_pkg::*;
(
    input  reg_vec_t vec,
    input  reg_idx_t start,
    output logic     found,
    output reg_idx_t index
);

    reg_idx_t cand;

    always_comb begin
        found = 1'b0;
        index = start;
        cand  = start;
        for (int k = 0; k < REG_COUNT; k++) begin
            cand = start + reg_idx_t'(k);
            if (!found && vec[reg_bit(cand)]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/register_request_encoder.sv
// Serialises a multi-hot register request into one index + load_enable per cycle.
// Latency: vector accepted at edge k, first grant after edge k+1; one bubble between vectors.
// Backpressure: request_ready only in IDLE; hold freezes the drain. REQUEST_ENCODER_ROUND_ROBIN_EN selects rotating priority.
module register_request_encoder
    import register_request_encoder_pkg::*;
#(
    parameter int LOW_INDEX_FIRST = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        request_valid,
    output logic        request_ready,
    input  logic [15:0] request_vector,
    input  logic        hold,
    output logic [3:0]  encoder_control,
    output logic        load_enable,
    output logic        done,
    output logic [4:0]  pending_count
);

    enc_state_t state, state_nxt;
    reg_vec_t   pend_vec, pend_vec_nxt, pend_clr;
    reg_vec_t   sel_vec;
    reg_idx_t   sel_start, sel_idx, grant_idx, ctrl_nxt;
    logic       sel_found, le_nxt, done_nxt;
    logic [4:0] cnt_nxt;

`ifdef REQUEST_ENCODER_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
    reg_idx_t last_issued;

    assign sel_start = last_issued + 4'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_issued <= 4'd15;
        end else if (state == ENC_DRAIN && !hold && sel_found) begin
            last_issued <= grant_idx;
        end
    end
`else
    localparam bit RR_EN = 1'b0;
    assign sel_start = '0;
`endif

    // Descending priority reuses the ascending search on a mirrored vector.
    localparam bit DESCEND = (LOW_INDEX_FIRST == 0) && !RR_EN;

    always_comb begin
        sel_vec = pend_vec;
        if (DESCEND) begin
            for (int k = 0; k < REG_COUNT; k++) begin
                sel_vec[k] = pend_vec[REG_COUNT-1-k];
            end
        end
    end

    priority_index_select u_sel (
        .vec   (sel_vec),
        .start (sel_start),
        .found (sel_found),
        .index (sel_idx)
    );

    assign grant_idx     = DESCEND ? reg_idx_t'(4'd15 - sel_idx) : sel_idx;
    assign pend_clr      = sel_found ? (pend_vec & ~reg_onehot(grant_idx)) : pend_vec;
    assign request_ready = (state == ENC_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ENC_IDLE;
            pend_vec        <= '0;
            encoder_control <= '0;
            load_enable     <= 1'b0;
            done            <= 1'b0;
            pending_count   <= '0;
        end else begin
            state           <= state_nxt;
            pend_vec        <= pend_vec_nxt;
            encoder_control <= ctrl_nxt;
            load_enable     <= le_nxt;
            done            <= done_nxt;
            pending_count   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ENC_IDLE:  if (request_valid) state_nxt = ENC_DRAIN;
            ENC_DRAIN: if (!hold && pend_clr == '0) state_nxt = ENC_IDLE;
            default:   state_nxt = ENC_IDLE;
        endcase
    end

    always_comb begin
        pend_vec_nxt = pend_vec;
        cnt_nxt      = pending_count;
        ctrl_nxt     = encoder_control;
        le_nxt       = 1'b0;
        done_nxt     = 1'b0;
        case (state)
            ENC_IDLE: begin
                if (request_valid) begin
                    pend_vec_nxt = request_vector;
                    cnt_nxt      = popcount(request_vector);
                end
            end
            ENC_DRAIN: begin
                if (!hold) begin
                    if (sel_found) begin
                        pend_vec_nxt = pend_clr;
                        cnt_nxt      = pending_count - 5'd1;
                        ctrl_nxt     = grant_idx;
                        le_nxt       = 1'b1;
                    end
                    // Final grant and completion share the same edge.
                    done_nxt = (pend_clr == '0);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_register_request_encoder.sv
// Directed bench: an ascending and a descending encoder share stimulus and are checked against hand-built sequences.
module tb_register_request_encoder;

    logic        clk;
    logic        reset_n;
    logic        request_valid;
    logic [15:0] request_vector;
    logic        hold;

    logic        a_rdy, a_le, a_done;
    logic [3:0]  a_ec;
    logic [4:0]  a_pc;
    logic        b_rdy, b_le, b_done;
    logic [3:0]  b_ec;
    logic [4:0]  b_pc;

    int total = 0;
    int bad   = 0;

`ifdef REQUEST_ENCODER_ROUND_ROBIN_EN
    localparam logic [63:0] BASIC_B_SEQ = 64'hF20;
`else
    localparam logic [63:0] BASIC_B_SEQ = 64'h02F;
`endif

    register_request_encoder #(.LOW_INDEX_FIRST(1)) u_asc (
        .clk             (clk),
        .reset_n         (reset_n),
        .request_valid   (request_valid),
        .request_ready   (a_rdy),
        .request_vector  (request_vector),
        .hold            (hold),
        .encoder_control (a_ec),
        .load_enable     (a_le),
        .done            (a_done),
        .pending_count   (a_pc)
    );

    register_request_encoder #(.LOW_INDEX_FIRST(0)) u_desc (
        .clk             (clk),
        .reset_n         (reset_n),
        .request_valid   (request_valid),
        .request_ready   (b_rdy),
        .request_vector  (request_vector),
        .hold            (hold),
        .encoder_control (b_ec),
        .load_enable     (b_le),
        .done            (b_done),
        .pending_count   (b_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Offers vec, then expects n back-to-back grants following the nibble lists (first grant in bits 3:0).
    task automatic run_vector(input string tag, input logic [15:0] vec, input int n,
                              input logic [63:0] a_seq, input logic [63:0] b_seq);
        request_valid  = 1'b1;
        request_vector = vec;
        step();
        check({tag, ":acc_pc"},  32'(a_pc),  32'(n));
        check({tag, ":acc_rdy"}, 32'(a_rdy), 32'(0));
        check({tag, ":acc_le"},  32'(a_le),  32'(0));
        request_valid  = 1'b0;
        request_vector = 16'h5A5A;
        for (int k = 0; k < n; k++) begin
            step();
            check($sformatf("%s:a_ec%0d", tag, k),   32'(a_ec),   32'(a_seq[4*k +: 4]));
            check($sformatf("%s:b_ec%0d", tag, k),   32'(b_ec),   32'(b_seq[4*k +: 4]));
            check($sformatf("%s:le%0d", tag, k),     32'(a_le),   32'(1));
            check($sformatf("%s:done%0d", tag, k),   32'(a_done), 32'(k == n - 1));
            check($sformatf("%s:b_done%0d", tag, k), 32'(b_done), 32'(k == n - 1));
            check($sformatf("%s:pc%0d", tag, k),     32'(a_pc),   32'(n - 1 - k));
        end
        step();
        check({tag, ":post_le"},   32'(a_le),   32'(0));
        check({tag, ":post_done"}, 32'(a_done), 32'(0));
        check({tag, ":post_rdy"},  32'(a_rdy),  32'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset_n        = 1'b0;
        request_valid  = 1'b0;
        request_vector = 16'h0000;
        hold           = 1'b0;
        step();
        check("rst:ec",   32'(a_ec),   32'(0));
        check("rst:le",   32'(a_le),   32'(0));
        check("rst:done", 32'(a_done), 32'(0));
        check("rst:pc",   32'(a_pc),   32'(0));
        check("rst:rdy",  32'(a_rdy),  32'(1));
        reset_n = 1'b1;
        step();

        run_vector("basic", 16'hA001, 3, 64'hF20, BASIC_B_SEQ);

        // Full vector with a two-cycle hold after grant 4 and a new vector in the final-grant cycle.
        request_valid  = 1'b1;
        request_vector = 16'hFFFF;
        step();
        check("full:acc_pc", 32'(a_pc), 32'(16));
        request_valid = 1'b0;
        for (int g = 0; g < 16; g++) begin
            step();
            check($sformatf("full:ec%0d", g),   32'(a_ec),   32'(g));
            check($sformatf("full:le%0d", g),   32'(a_le),   32'(1));
            check($sformatf("full:pc%0d", g),   32'(a_pc),   32'(15 - g));
            check($sformatf("full:done%0d", g), 32'(a_done), 32'(g == 15));
            if (g == 4) begin
                hold = 1'b1;
                for (int h = 0; h < 2; h++) begin
                    step();
                    check($sformatf("hold:le%0d", h),   32'(a_le),   32'(0));
                    check($sformatf("hold:ec%0d", h),   32'(a_ec),   32'(4));
                    check($sformatf("hold:pc%0d", h),   32'(a_pc),   32'(11));
                    check($sformatf("hold:done%0d", h), 32'(a_done), 32'(0));
                end
                hold = 1'b0;
            end
            if (g == 15) begin
                check("b2b:rdy_final", 32'(a_rdy), 32'(1));
                request_valid  = 1'b1;
                request_vector = 16'h8000;
            end
        end
        step();
        check("b2b:bubble_le", 32'(a_le),  32'(0));
        check("b2b:bubble_pc", 32'(a_pc),  32'(1));
        check("b2b:bubble_rdy", 32'(a_rdy), 32'(0));
        request_valid = 1'b0;
        step();
        check("b2b:ec",   32'(a_ec),   32'(0));
        check("b2b:le",   32'(a_le),   32'(1));
        check("b2b:done", 32'(a_done), 32'(1));
        step();
        check("b2b:post_le", 32'(a_le), 32'(0));

        // Zero vector completes with no grant.
        request_valid  = 1'b1;
        request_vector = 16'h0000;
        step();
        check("zero:acc_rdy", 32'(a_rdy), 32'(0));
        check("zero:acc_le",  32'(a_le),  32'(0));
        request_valid = 1'b0;
        step();
        check("zero:done", 32'(a_done), 32'(1));
        check("zero:le",   32'(a_le),   32'(0));
        step();
        check("zero:rdy",       32'(a_rdy),  32'(1));
        check("zero:done_drop", 32'(a_done), 32'(0));

        // Reset mid-drain.
        request_valid  = 1'b1;
        request_vector = 16'hFFFF;
        step();
        request_valid = 1'b0;
        step();
        step();
        step();
        check("rstd:ec_pre", 32'(a_ec), 32'(2));
        #1 reset_n = 1'b0;
        #1;
        check("rstd:ec",   32'(a_ec),   32'(0));
        check("rstd:le",   32'(a_le),   32'(0));
        check("rstd:done", 32'(a_done), 32'(0));
        check("rstd:pc",   32'(a_pc),   32'(0));
        check("rstd:rdy",  32'(a_rdy),  32'(1));
        step();
        reset_n = 1'b1;
        step();
        check("rstd:rel_le",  32'(a_le),  32'(0));
        check("rstd:rel_rdy", 32'(a_rdy), 32'(1));
        step();
        check("rstd:rel_le2", 32'(a_le), 32'(0));
        check("rstd:rel_pc",  32'(a_pc), 32'(0));

`ifdef REQUEST_ENCODER_ROUND_ROBIN_EN
        run_vector("rr1", 16'h8001, 2, 64'hF0, 64'hF0);
        run_vector("rr2", 16'h8001, 2, 64'hF0, 64'hF0);
        run_vector("rr3", 16'h4001, 2, 64'hF1, 64'hF1);
        run_vector("rr4", 16'h0400, 1, 64'h5, 64'h5);
        run_vector("rr5", 16'hFFFF, 16, 64'h543210FEDCBA9876, 64'h543210FEDCBA9876);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/register_request_encoder.md
Name: register_request_encoder

Overview:
- Write-side companion to the register file's 4-to-16 write-enable decoder; drives the decoder's 4-bit control and load_enable inputs.
- Accepts a 16-bit multi-hot register request vector. Bit 15 selects R0 and bit 0 selects R15, the same one-hot bit order the decoder produces.
- Serialises the vector into one 4-bit register index plus one load_enable per cycle, and signals completion.
- Used for multi-register writeback, such as block loads and context restore.

Parameters:
- LOW_INDEX_FIRST, 1, 1 = grant ascending register index (R0 first); 0 = descending (R15 first).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- request_valid  input  1  request vector offered
- request_ready  output  1  encoder can accept a vector; combinational, equals (state == IDLE)
- request_vector  input  16  requested registers; bit (15-i) means register i
- hold  input  1  stall; freezes the drain
- encoder_control  output  4  register index to the decoder; registered
- load_enable  output  1  write strobe for encoder_control; registered
- done  output  1  one-cycle pulse when the vector is fully issued; registered
- pending_count  output  5  number of bits still pending, 0..16; registered

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE, pending register=0, encoder_control=0, load_enable=0, done=0, pending_count=0. Reset mid-drain discards all remaining requests with no further grants.
- States:
  - IDLE: request_ready=1, load_enable=0, done=0. At the edge where request_valid=1, capture request_vector into the pending register, set pending_count=popcount(request_vector), go to DRAIN.
  - DRAIN: request_ready=0.
    - At each edge with hold=0 and pending nonzero: select the index i. With LOW_INDEX_FIRST=1, i is the smallest i whose bit (15-i) is set; with LOW_INDEX_FIRST=0, the largest. Register encoder_control=i and load_enable=1, clear that bit, decrement pending_count.
    - If that bit was the last one: done=1 at the same edge (coincident with the final load_enable), state goes to IDLE.
    - At an edge with hold=0 and pending empty (zero vector accepted): load_enable=0, done=1, go to IDLE.
    - At an edge with hold=1: load_enable=0, done=0, encoder_control keeps its value, pending register and pending_count unchanged.
- Latency: vector accepted at edge k; first load_enable visible after edge k+1. An N-bit vector gives N consecutive load_enable cycles when hold=0.
- Back-to-back vectors: request_ready is high during the final-grant cycle, so a new vector is captured there. This costs one bubble cycle between vectors.
- hold is ignored in IDLE. request_vector is sampled only at acceptance; later changes have no effect.
- load_enable and done are single-cycle per event, never held across cycles.

Optional Feature:
- Macro: REQUEST_ENCODER_ROUND_ROBIN_EN.
- Defined:
  - Adds a last_issued register, reset to 15, which persists across vectors.
  - The search starts at (last_issued+1) mod 16 and wraps ascending, e.g. last 15 searches 0..15 and last 14 searches 15,0,1,...
  - LOW_INDEX_FIRST is ignored.
  - last_issued updates on every grant.
- Undefined: fixed priority per LOW_INDEX_FIRST; no last_issued register.

Decomposition:
- Shared register-file package holds:
  - REG_COUNT=16 and REG_INDEX_W=4;
  - state encoding constants ENC_IDLE and ENC_DRAIN;
  - the bit-order convention, with a function mapping index i to bit (15-i).
- One natural sub-module, priority_index_select: combinational 16-bit vector plus start index in, found flag plus 4-bit index out. Shared between the fixed and round-robin modes.

Test Plan:
- Reset during drain: vector 16'hFFFF; assert reset_n=0 after 3 grants -> all outputs 0 immediately; after release, request_ready=1, no load_enable.
- Basic order: vector 16'b1010_0000_0000_0001, LOW_INDEX_FIRST=1 -> encoder_control 0,2,15 on three consecutive load_enable cycles; done only with 15; pending_count 3,2,1,0.
- Descending: the same vector with LOW_INDEX_FIRST=0 -> 15,2,0.
- Full, hold and back-to-back:
  - 16'hFFFF -> 16 consecutive grants 0..15.
  - hold=1 for 2 cycles after grant 4 -> two cycles of load_enable=0 with encoder_control=4, then 5 resumes.
  - A new vector 16'h8000 presented during the final-grant cycle -> accepted; grant 0 follows one bubble cycle later.
- Zero vector: 16'h0000 accepted -> no load_enable; done=1 at edge k+1; request_ready=1 the following cycle.
- Round robin (macro on):
  - 16'h8001 -> grants 0 then 15.
  - Next vector 16'h8001 -> 0 then 15.
  - Next vector 16'h4001 with last_issued=15 -> 1 then 15.
  - After a vector granting only index 5, vector 16'hFFFF -> first grant 6, wrapping to end at 5.
